mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
Execute-stage controller for the multi-cycle multiply/divide unit, and owner of the architectural HI/LO registers.
- Decodes HI/LO-class ops from EX.
- Latches operands, drives the start-level handshake of the mul/div unit and stalls the pipeline while it runs.
- Writes HI/LO on completion, services MTHI/MTLO/MFHI/MFLO, and handles flush while the unit is busy.

Parameters:
- DW, 32, operand/HI/LO width.
- COOL_CYC, 1, cycles md_start_o is held low after each unit run (unit clears ready_o only while start is low).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- valid_i  in  1  EX holds a valid instruction.
- op_i  in  4  operation code (mdu_pkg).
- rs_i  in  DW  operand A / dividend / MT source.
- rt_i  in  DW  operand B / divisor.
- flush_i  in  1  EX instruction killed this cycle.
- stall_o  out  1  hold EX and earlier stages.
- rdata_o  out  DW  MFHI/MFLO result.
- hi_o  out  DW  architectural HI.
- lo_o  out  DW  architectural LO.
- md_sel_o  out  1  1=multiply, 0=divide.
- md_signed_o  out  1  signed operation.
- md_a_o  out  DW  latched operand A.
- md_b_o  out  DW  latched operand B.
- md_start_o  out  1  unit start level.
- md_annul_o  out  1  result will be discarded (informational).
- md_result_i  in  2*DW  product {hi,lo}; for divide, {remainder,quotient}.
- md_ready_i  in  1  unit result valid.

Behaviour:
- Reset: state IDLE, hi/lo=0. All outputs 0 except:
  - md_a_o/md_b_o = 0.
  - rdata_o reflects hi/lo.
- Op codes: NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8.
  - MADD=9, MADDU=10, MSUB=11, MSUBU=12 exist only with the optional feature; otherwise they decode as NOP.
- Signed: md_signed_o=1 for MULT, DIV, MADD, MSUB.
- Registered outputs: md_sel_o, md_signed_o, md_a_o, md_b_o are registered at issue. They stay stable until state returns to IDLE.
- Derived outputs: md_start_o=(state∈{RUN,DRAIN}); md_annul_o=(state==DRAIN).
- States: IDLE, RUN, ACC, DRAIN, COOL.
- IDLE:
  - Valid mul/div op, not flushed: latch operands; stall_o=1; next state RUN.
  - DIV/DIVU with rt_i==0: no issue, no stall. HI<=rs_i, LO<=all-ones at this edge. Stay IDLE.
  - MTHI/MTLO: write at this edge, no stall.
  - MFHI/MFLO: rdata_o = current hi/lo register (combinational).
  - flush_i with a mul/div op: no issue.
- RUN:
  - stall_o=1 while md_ready_i=0.
  - On md_ready_i=1 (plain mul/div): stall_o=0, {HI,LO}<=md_result_i, next state COOL.
  - On md_ready_i=1 (accumulate op): stall_o stays 1, product captured, next state ACC.
  - flush_i=1 while RUN and md_ready_i=0: next state DRAIN.
  - md_start_o is never dropped mid-run; the unit's step counter only resets on completion.
- DRAIN:
  - start held high until md_ready_i=1; result discarded; then COOL.
  - stall_o=1 only if valid_i with any HI/LO-class op.
- COOL:
  - md_start_o=0 for COOL_CYC cycles, then IDLE.
  - Any valid HI/LO-class op stalls; other ops pass.
- Timing:
  - Back-to-back MULT: second stalls RUN+COOL of the first, plus its own issue cycle.
  - Total stall of an isolated MULT = unit latency + 1 issue cycle.
- flush_i in the ready cycle: the result is still discarded, with no HI/LO write.
- Reset mid-run: immediate IDLE. The unit is reset by the same rst.

Optional Feature:
- MDU_MADD_EN defined:
  - MADD/MADDU/MSUB/MSUBU issue as multiplies.
  - ACC state: one cycle, stall_o=0. {HI,LO} <= {HI,LO} ± product, 64-bit wrap; then COOL.
  - flush_i in ACC suppresses the write.
- Undefined: codes 9-12 are NOP, the ACC state and 64-bit adder are absent, and RUN always goes to COOL.

Decomposition:
- mdu_pkg: op-code localparams, state encoding, helper is_muldiv(op)/is_hilo(op).
- Optional sub-module hilo_regs: HI/LO storage with a single 64-bit write port plus separate 32-bit MTHI/MTLO writes. Write priority: completion > MT.

Test Plan:
- MULT rs=-3, rt=7 -> stall through RUN, HI=0xFFFFFFFF, LO=0xFFFFFFEB; next MFLO returns 0xFFFFFFEB.
- DIVU rs=100, rt=7 -> HI=2, LO=14. Then immediate MULTU 5×6: md_start_o low ≥1 cycle between runs; LO=30, HI=0.
- DIV rs=9, rt=0 -> no stall, md_start_o stays 0, HI=9, LO=0xFFFFFFFF.
- MULT then flush_i 5 cycles later -> DRAIN, md_annul_o=1 until ready, HI/LO unchanged. A following MTHI 0x1234 stalls until IDLE, then HI=0x1234.
- rst asserted mid-RUN -> next cycle state IDLE, all outputs 0, hi/lo=0.
- With MDU_MADD_EN: HI/LO=0/10, MADDU 4×5 -> LO=30; MSUB 1×40 -> {HI,LO}=0xFFFFFFFF_FFFFFFF6.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared decode for the multiply/divide controller: op codes, FSM encoding and op-class helpers.
// Optional multiply-accumulate ops are enabled by defining MDU_MADD_EN.
package mdu_pkg;

  localparam logic [3:0] OpNop   = 4'd0;
  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMthi  = 4'd5;
  localparam logic [3:0] OpMtlo  = 4'd6;
  localparam logic [3:0] OpMfhi  = 4'd7;
  localparam logic [3:0] OpMflo  = 4'd8;
  localparam logic [3:0] OpMadd  = 4'd9;
  localparam logic [3:0] OpMaddu = 4'd10;
  localparam logic [3:0] OpMsub  = 4'd11;
  localparam logic [3:0] OpMsubu = 4'd12;

`ifdef MDU_MADD_EN
  localparam bit MaddEn = 1'b1;
`else
  localparam bit MaddEn = 1'b0;
`endif

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRun   = 3'd1,
    StAcc   = 3'd2,
    StDrain = 3'd3,
    StCool  = 3'd4
  } mdu_state_e;

  // Accumulate ops decode as NOP unless the feature is built in.
  function automatic logic is_acc(logic [3:0] op);
    return MaddEn && (op inside {OpMadd, OpMaddu, OpMsub, OpMsubu});
  endfunction

  function automatic logic is_sub(logic [3:0] op);
    return MaddEn && (op inside {OpMsub, OpMsubu});
  endfunction

  function automatic logic is_mul(logic [3:0] op);
    return (op inside {OpMult, OpMultu}) || is_acc(op);
  endfunction

  function automatic logic is_div(logic [3:0] op);
    return op inside {OpDiv, OpDivu};
  endfunction

  function automatic logic is_signed(logic [3:0] op);
    return (op inside {OpMult, OpDiv}) || (MaddEn && (op inside {OpMadd, OpMsub}));
  endfunction

  function automatic logic is_muldiv(logic [3:0] op);
    return is_mul(op) || is_div(op);
  endfunction

  // Any op that reads or writes HI/LO.
  function automatic logic is_hilo(logic [3:0] op);
    return is_muldiv(op) || (op inside {OpMthi, OpMtlo, OpMfhi, OpMflo});
  endfunction

endpackage

// File: rtl/mdu_ctrl_hilo_regs.sv
// Architectural HI/LO storage: one 64-bit write port (unit completion, divide-by-zero,
// accumulate) that takes priority over the separate MTHI/MTLO writes.
module hilo_regs
  import mdu_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en_i,
  input  logic [2*DW-1:0] wr_data_i,
  input  logic            mthi_en_i,
  input  logic            mtlo_en_i,
  input  logic [DW-1:0]   mt_data_i,
  output logic [DW-1:0]   hi_o,
  output logic [DW-1:0]   lo_o
);

  logic [DW-1:0] hi_q, lo_q;

  // HI/LO update, completion before MT writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (wr_en_i) begin
      {hi_q, lo_q} <= wr_data_i;
    end else begin
      if (mthi_en_i) hi_q <= mt_data_i;
      if (mtlo_en_i) lo_q <= mt_data_i;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/mdu_ctrl.sv
// Execute-stage controller for the multi-cycle mul/div unit; owns HI/LO.
// Define MDU_MADD_EN to add MADD/MADDU/MSUB/MSUBU and the accumulate state.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned DW       = 32,
  parameter int unsigned COOL_CYC = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic [3:0]      op_i,
  input  logic [DW-1:0]   rs_i,
  input  logic [DW-1:0]   rt_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic [DW-1:0]   rdata_o,
  output logic [DW-1:0]   hi_o,
  output logic [DW-1:0]   lo_o,
  output logic            md_sel_o,
  output logic            md_signed_o,
  output logic [DW-1:0]   md_a_o,
  output logic [DW-1:0]   md_b_o,
  output logic            md_start_o,
  output logic            md_annul_o,
  input  logic [2*DW-1:0] md_result_i,
  input  logic            md_ready_i
);

  localparam int unsigned     CntW     = (COOL_CYC > 1) ? $clog2(COOL_CYC) : 1;
  localparam logic [CntW-1:0] CoolInit = CntW'(COOL_CYC - 1);

  mdu_state_e      state_q, state_d;
  logic [CntW-1:0] cool_q, cool_d;
  logic            sel_q, signed_q;
  logic [DW-1:0]   a_q, b_q;
  logic            issue;
  logic            wr_en, mthi_en, mtlo_en;
  logic [2*DW-1:0] wr_data;
  logic [DW-1:0]   hi, lo;

`ifdef MDU_MADD_EN
  logic            acc_q, sub_q;
  logic [2*DW-1:0] prod_q, acc_sum;

  assign acc_sum = sub_q ? ({hi, lo} - prod_q) : ({hi, lo} + prod_q);
`endif

  // Next state, stall and HI/LO write requests.
  always_comb begin
    state_d = state_q;
    cool_d  = (state_q == StCool) ? (cool_q - CntW'(1)) : CoolInit;
    stall_o = 1'b0;
    issue   = 1'b0;
    wr_en   = 1'b0;
    wr_data = md_result_i;
    mthi_en = 1'b0;
    mtlo_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (valid_i && !flush_i) begin
          if (is_muldiv(op_i)) begin
            // Divide by zero never reaches the unit.
            if (is_div(op_i) && (rt_i == '0)) begin
              wr_en   = 1'b1;
              wr_data = {rs_i, {DW{1'b1}}};
            end else begin
              issue   = 1'b1;
              stall_o = 1'b1;
              state_d = StRun;
            end
          end else begin
            mthi_en = (op_i == OpMthi);
            mtlo_en = (op_i == OpMtlo);
          end
        end
      end
      StRun: begin
        if (!md_ready_i) begin
          stall_o = 1'b1;
          if (flush_i) state_d = StDrain;
        end else begin
          state_d = StCool;
          if (!flush_i) begin
`ifdef MDU_MADD_EN
            if (acc_q) begin
              stall_o = 1'b1;
              state_d = StAcc;
            end else begin
              wr_en = 1'b1;
            end
`else
            wr_en = 1'b1;
`endif
          end
        end
      end
`ifdef MDU_MADD_EN
      StAcc: begin
        state_d = StCool;
        if (!flush_i) begin
          wr_en   = 1'b1;
          wr_data = acc_sum;
        end
      end
`endif
      StDrain: begin
        stall_o = valid_i && is_hilo(op_i);
        if (md_ready_i) state_d = StCool;
      end
      StCool: begin
        stall_o = valid_i && is_hilo(op_i);
        if (cool_q == '0) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, cool-down counter and operands latched at issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cool_q   <= '0;
      sel_q    <= 1'b0;
      signed_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      state_q <= state_d;
      cool_q  <= cool_d;
      if (issue) begin
        sel_q    <= is_mul(op_i);
        signed_q <= is_signed(op_i);
        a_q      <= rs_i;
        b_q      <= rt_i;
      end
    end
  end

`ifdef MDU_MADD_EN
  // Accumulate direction at issue, product when the unit finishes.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= 1'b0;
      sub_q  <= 1'b0;
      prod_q <= '0;
    end else begin
      if (issue) begin
        acc_q <= is_acc(op_i);
        sub_q <= is_sub(op_i);
      end
      if ((state_q == StRun) && md_ready_i) prod_q <= md_result_i;
    end
  end
`endif

  hilo_regs #(
    .DW(DW)
  ) u_hilo_regs (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_en),
    .wr_data_i (wr_data),
    .mthi_en_i (mthi_en),
    .mtlo_en_i (mtlo_en),
    .mt_data_i (rs_i),
    .hi_o      (hi),
    .lo_o      (lo)
  );

  assign hi_o        = hi;
  assign lo_o        = lo;
  assign rdata_o     = (op_i == OpMfhi) ? hi : lo;
  assign md_sel_o    = sel_q;
  assign md_signed_o = signed_q;
  assign md_a_o      = a_q;
  assign md_b_o      = b_q;
  assign md_start_o  = (state_q == StRun) || (state_q == StDrain);
  assign md_annul_o  = (state_q == StDrain);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl with a behavioural mul/div unit of configurable latency.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  localparam int DW       = 32;
  localparam int COOL_CYC = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid_i = 1'b0;
  logic [3:0]    op_i = OpNop;
  logic [31:0]   rs_i = '0;
  logic [31:0]   rt_i = '0;
  logic          flush_i = 1'b0;
  logic          stall_o, md_sel_o, md_signed_o, md_start_o, md_annul_o;
  logic [31:0]   rdata_o, hi_o, lo_o, md_a_o, md_b_o;
  logic [63:0]   res_q = '0;
  logic          rdy_q = 1'b0;

  mdu_ctrl #(
    .DW       (DW),
    .COOL_CYC (COOL_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid_i),
    .op_i        (op_i),
    .rs_i        (rs_i),
    .rt_i        (rt_i),
    .flush_i     (flush_i),
    .stall_o     (stall_o),
    .rdata_o     (rdata_o),
    .hi_o        (hi_o),
    .lo_o        (lo_o),
    .md_sel_o    (md_sel_o),
    .md_signed_o (md_signed_o),
    .md_a_o      (md_a_o),
    .md_b_o      (md_b_o),
    .md_start_o  (md_start_o),
    .md_annul_o  (md_annul_o),
    .md_result_i (res_q),
    .md_ready_i  (rdy_q)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          lat     = 4;
  int          cnt     = 0;
  int          low_cnt = 0;
  int          last_gap = -1;
  logic        prev_start = 1'b0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi = '0, m_lo = '0;

  function automatic logic [63:0] unit_calc(input logic sel, sgn, input logic [31:0] a, b);
    logic signed [63:0] sa, sb;
    logic signed [31:0] qa, qb;
    if (sel) begin
      if (!sgn) return {32'h0, a} * {32'h0, b};
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return sa * sb;
    end
    if (b == '0) return '0;
    if (!sgn) return {a % b, a / b};
    qa = a;
    qb = b;
    return {qa % qb, qa / qb};
  endfunction

  // Unit model: counts while start is high, holds ready until start drops.
  always @(posedge clk) begin
    if (rst || !md_start_o) begin
      rdy_q <= 1'b0;
      cnt   <= 0;
    end else if (!rdy_q) begin
      if (cnt + 1 >= lat) begin
        rdy_q <= 1'b1;
        res_q <= unit_calc(md_sel_o, md_signed_o, md_a_o, md_b_o);
      end
      cnt <= cnt + 1;
    end
  end

  // Length of the last low gap on md_start_o before it rose.
  always @(negedge clk) begin
    if (md_start_o) begin
      if (!prev_start) last_gap <= low_cnt;
      low_cnt <= 0;
    end else begin
      low_cnt <= low_cnt + 1;
    end
    prev_start <= md_start_o;
  end

  // Reference HI/LO effect of one instruction.
  function automatic bit ref_write(input logic [3:0] op, input logic [31:0] rs, rt, hi, lo,
                                   output logic [63:0] val);
    int q, r;
    val = {hi, lo};
    case (op)
      OpMult:  val = longint'($signed(rs)) * longint'($signed(rt));
      OpMultu: val = {32'h0, rs} * {32'h0, rt};
      OpDiv: begin
        if (rt == 0) val = {rs, 32'hFFFF_FFFF};
        else begin
          q = int'($signed(rs)) / int'($signed(rt));
          r = int'($signed(rs)) % int'($signed(rt));
          val = {r, q};
        end
      end
      OpDivu:  val = (rt == 0) ? {rs, 32'hFFFF_FFFF} : {rs % rt, rs / rt};
      OpMthi:  val = {rs, lo};
      OpMtlo:  val = {hi, rs};
`ifdef MDU_MADD_EN
      OpMadd:  val = {hi, lo} + 64'(longint'($signed(rs)) * longint'($signed(rt)));
      OpMaddu: val = {hi, lo} + ({32'h0, rs} * {32'h0, rt});
      OpMsub:  val = {hi, lo} - 64'(longint'($signed(rs)) * longint'($signed(rt)));
      OpMsubu: val = {hi, lo} - ({32'h0, rs} * {32'h0, rt});
`endif
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  // Present one instruction (called at posedge+1) and hold it until it retires.
  task automatic exec(input logic [3:0] op, input logic [31:0] rs, rt,
                      output int stalls, output logic [31:0] rd);
    logic [63:0] v;
    if (ref_write(op, rs, rt, m_hi, m_lo, v)) begin
      exp_q.push_back(v);
      {m_hi, m_lo} = v;
    end
    valid_i = 1'b1;
    op_i = op;
    rs_i = rs;
    rt_i = rt;
    #1;
    stalls = 0;
    while (stall_o !== 1'b0 && stalls < 200) begin
      stalls++;
      @(posedge clk);
      #1;
    end
    if (stalls >= 200) begin
      n_tests++;
      n_fail++;
      $display("FAIL exec_timeout: op %0d still stalled after %0d cycles, required release", op,
               stalls);
    end
    rd = rdata_o;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    op_i = OpNop;
    rs_i = '0;
    rt_i = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    n_tests++;
    if ({stall_o, md_start_o, md_annul_o, md_sel_o, md_signed_o, md_a_o, md_b_o, hi_o, lo_o,
         rdata_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got a=%h b=%h hi=%h lo=%h st=%b, required all zero", md_a_o,
               md_b_o, hi_o, lo_o, {stall_o, md_start_o, md_annul_o, md_sel_o, md_signed_o});
    end
  endtask

  task automatic test_mult();
    int s;
    logic [31:0] rd;
    logic [63:0] e;
    exec(OpMult, 32'hFFFF_FFFD, 32'd7, s, rd);
    n_tests++;
    if (s !== lat + 1) begin n_fail++; $display("FAIL mult_stall: got %0d required %0d", s, lat + 1); end
    e = exp_q.pop_front();
    n_tests++;
    if ({hi_o, lo_o} !== e) begin n_fail++; $display("FAIL mult_hilo: got %h required %h", {hi_o, lo_o}, e); end
    n_tests++;
    if (md_signed_o !== 1'b1 || md_sel_o !== 1'b1) begin
      n_fail++;
      $display("FAIL mult_ctrl: got sel=%b signed=%b required 1 1", md_sel_o, md_signed_o);
    end
    exec(OpMflo, '0, '0, s, rd);
    n_tests++;
    if (s !== COOL_CYC) begin n_fail++; $display("FAIL mflo_stall: got %0d required %0d", s, COOL_CYC); end
    n_tests++;
    if (rd !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mflo_rdata: got %h required ffffffeb", rd); end
    exec(OpMfhi, '0, '0, s, rd);
    n_tests++;
    if (rd !== m_hi) begin n_fail++; $display("FAIL mfhi_rdata: got %h required %h", rd, m_hi); end
  endtask

  task automatic test_back_to_back();
    int s;
    logic [31:0] rd;
    logic [63:0] e;
    exec(OpDivu, 32'd100, 32'd7, s, rd);
    e = exp_q.pop_front();
    n_tests++;
    if ({hi_o, lo_o} !== e) begin n_fail++; $display("FAIL divu_hilo: got %h required %h", {hi_o, lo_o}, e); end
    n_tests++;
    if ({md_sel_o, md_signed_o, md_a_o, md_b_o} !== {2'b00, 32'd100, 32'd7}) begin
      n_fail++;
      $display("FAIL divu_operands: got sel=%b sgn=%b a=%0d b=%0d required 0 0 100 7", md_sel_o,
               md_signed_o, md_a_o, md_b_o);
    end
    exec(OpMultu, 32'd5, 32'd6, s, rd);
    n_tests++;
    if (s !== COOL_CYC + 1 + lat) begin
      n_fail++;
      $display("FAIL b2b_stall: got %0d required %0d", s, COOL_CYC + 1 + lat);
    end
    e = exp_q.pop_front();
    n_tests++;
    if ({hi_o, lo_o} !== e) begin n_fail++; $display("FAIL multu_hilo: got %h required %h", {hi_o, lo_o}, e); end
    n_tests++;
    if (last_gap !== COOL_CYC + 1) begin
      n_fail++;
      $display("FAIL start_gap: got %0d low cycles required %0d", last_gap, COOL_CYC + 1);
    end
  endtask

  task automatic test_div_zero();
    int s;
    logic [31:0] rd;
    logic [63:0] e;
    @(posedge clk);
    #1;
    exec(OpDiv, 32'd9, 32'd0, s, rd);
    n_tests++;
    if (s !== 0) begin n_fail++; $display("FAIL div0_stall: got %0d required 0", s); end
    n_tests++;
    if (md_start_o !== 1'b0) begin n_fail++; $display("FAIL div0_start: got %b required 0", md_start_o); end
    e = exp_q.pop_front();
    n_tests++;
    if ({hi_o, lo_o} !== e) begin n_fail++; $display("FAIL div0_hilo: got %h required %h", {hi_o, lo_o}, e); end
    exec(OpMtlo, 32'h55, '0, s, rd);
    e = exp_q.pop_front();
    n_tests++;
    if (s !== 0 || {hi_o, lo_o} !== e) begin
      n_fail++;
      $display("FAIL mtlo: got stall %0d hilo %h required 0 %h", s, {hi_o, lo_o}, e);
    end
  endtask

  task automatic test_flush_drain();
    int n = 0;
    int bad = 0;
    logic [63:0] e;
    lat = 8;
    valid_i = 1'b1;
    op_i = OpMult;
    rs_i = 32'd2;
    rt_i = 32'd3;
    #1;
    for (int c = 0; c < 5; c++) begin
      if (stall_o !== 1'b1) bad++;
      @(posedge clk);
      #1;
    end
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    op_i = OpMthi;
    rs_i = 32'h1234;
    #1;
    while (md_annul_o === 1'b1 && n < 50) begin
      if (stall_o !== 1'b1 || md_start_o !== 1'b1) bad++;
      n++;
      @(posedge clk);
      #1;
    end
    n_tests++;
    if (n !== lat - 4) begin n_fail++; $display("FAIL drain_cycles: got %0d required %0d", n, lat - 4); end
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("FAIL drain_stall: got %0d bad cycles required 0", bad); end
    n_tests++;
    if ({hi_o, lo_o} !== {m_hi, m_lo}) begin
      n_fail++;
      $display("FAIL drain_hilo: got %h required %h", {hi_o, lo_o}, {m_hi, m_lo});
    end
    n_tests++;
    if (md_start_o !== 1'b0 || stall_o !== 1'b1) begin
      n_fail++;
      $display("FAIL cool_mthi: got start=%b stall=%b required 0 1", md_start_o, stall_o);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (stall_o !== 1'b0) begin n_fail++; $display("FAIL idle_mthi_stall: got %b required 0", stall_o); end
    m_hi = 32'h1234;
    exp_q.push_back({m_hi, m_lo});
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    op_i = OpNop;
    rs_i = '0;
    rt_i = '0;
    e = exp_q.pop_front();
    n_tests++;
    if ({hi_o, lo_o} !== e) begin n_fail++; $display("FAIL mthi_after_drain: got %h required %h", {hi_o, lo_o}, e); end
    lat = 4;
  endtask

  task automatic test_flush_ready();
    valid_i = 1'b1;
    op_i = OpMult;
    rs_i = 32'd5;
    rt_i = 32'd5;
    #1;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    flush_i = 1'b1;
    #1;
    n_tests++;
    if (stall_o !== 1'b0) begin n_fail++; $display("FAIL ready_flush_stall: got %b required 0", stall_o); end
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    valid_i = 1'b0;
    op_i = OpNop;
    n_tests++;
    if ({hi_o, lo_o} !== {m_hi, m_lo} || md_start_o !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_flush_hilo: got %h start=%b required %h 0", {hi_o, lo_o}, md_start_o,
               {m_hi, m_lo});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_run();
    int s;
    logic [31:0] rd;
    logic [63:0] e;
    valid_i = 1'b1;
    op_i = OpMult;
    rs_i = 32'd7;
    rt_i = 32'd9;
    repeat (2) @(posedge clk);
    #1;
    valid_i = 1'b0;
    op_i = OpNop;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_hi = '0;
    m_lo = '0;
    n_tests++;
    if ({stall_o, md_start_o, md_annul_o, md_sel_o, md_signed_o, md_a_o, md_b_o, hi_o, lo_o,
         rdata_o} !== '0) begin
      n_fail++;
      $display("FAIL midrun_reset: got a=%h b=%h hi=%h lo=%h st=%b, required all zero", md_a_o,
               md_b_o, hi_o, lo_o, {stall_o, md_start_o, md_annul_o, md_sel_o, md_signed_o});
    end
    exec(OpMultu, 32'd3, 32'd3, s, rd);
    e = exp_q.pop_front();
    n_tests++;
    if (s !== lat + 1 || {hi_o, lo_o} !== e) begin
      n_fail++;
      $display("FAIL post_reset_mult: got stall %0d hilo %h required %0d %h", s, {hi_o, lo_o},
               lat + 1, e);
    end
  endtask

  task automatic test_accumulate();
    int s;
    logic [31:0] rd;
    logic [63:0] e;
`ifdef MDU_MADD_EN
    exec(OpMthi, 32'd0, '0, s, rd);
    void'(exp_q.pop_front());
    exec(OpMtlo, 32'd10, '0, s, rd);
    void'(exp_q.pop_front());
    exec(OpMaddu, 32'd4, 32'd5, s, rd);
    e = exp_q.pop_front();
    n_tests++;
    if (s !== lat + 2 || {hi_o, lo_o} !== e) begin
      n_fail++;
      $display("FAIL maddu: got stall %0d hilo %h required %0d %h", s, {hi_o, lo_o}, lat + 2, e);
    end
    exec(OpMsub, 32'd1, 32'd40, s, rd);
    e = exp_q.pop_front();
    n_tests++;
    if ({hi_o, lo_o} !== 64'hFFFF_FFFF_FFFF_FFF6 || {hi_o, lo_o} !== e) begin
      n_fail++;
      $display("FAIL msub: got %h required %h", {hi_o, lo_o}, e);
    end
`else
    @(posedge clk);
    #1;
    e = {m_hi, m_lo};
    exec(OpMadd, 32'd1, 32'd2, s, rd);
    n_tests++;
    if (s !== 0 || md_start_o !== 1'b0 || {hi_o, lo_o} !== e) begin
      n_fail++;
      $display("FAIL madd_as_nop: got stall %0d start %b hilo %h required 0 0 %h", s, md_start_o,
               {hi_o, lo_o}, e);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_mult();
    test_back_to_back();
    test_div_zero();
    test_flush_drain();
    test_flush_ready();
    test_reset_mid_run();
    test_accumulate();
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
